control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  single clock; all state changes on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ir  in  32  IR register contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-004 bus_src  out  11  one-hot bus drivers {HIout,LOout,Zhighout,Zlowout,PCout,IRout,MDRout,INout,Cout,Yout,MARout}; bit order fixed in package.
REQ-005 reg_ctl  out  6  {Gra,Grb,Grc,Rin,Rout,BAout}.
REQ-006 ld_en  out  10  {HIin,LOin,PCin,IRin,Zin,Yin,MARin,MDRin,CONin,OUT_Portin}.
REQ-007 alu_op  out  13  one-hot {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}.
REQ-008 mem_ctl  out  4  {Read,IncPC,read_mem,write_mem}; write_mem is always 0 in this revision.
REQ-009 con_reset  out  1  CON flip-flop clear.
REQ-010 run  out  1  1 while executing; 0 after halt.
REQ-011 illegal  out  1  one-cycle pulse in T3 for an unsupported opcode.

Function
REQ-012 States: RST, T0..T6, HALT; each T-step lasts exactly one clock.
REQ-013 Outputs are combinational (Moore) from state and ir[31:27]; all unlisted outputs are 0 in every step.
REQ-014 Fetch, every instruction: T0 IncPC,MARin,PCin; T1 MDRin,Read,read_mem; T2 MDRout,IRin,Read.
REQ-015 Decode in T3 uses ir directly; ir is stable from T3 until the next T2.
REQ-016 R-type ALU (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011): T3 Grb,Rout,Yin; T4 Grc,Rout,op,Zin; T5 Zlowout,Gra,Rin; then T0 (6 cycles total).
REQ-017 Immediate (addi 01100 ADD, andi 01101 AND, ori 01110 OR): T3 Grb,Rout,Yin; T4 Cout,op,Zin; T5 Zlowout,Gra,Rin; then T0.
REQ-018 div 01111 / mul 10000: T3 Gra,Rout,Yin; T4 Grb,Rout,op,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin; then T0 (7 cycles).
REQ-019 neg 10001 / not 10010: T3 Grb,Rout,op,Zin; T4 Zlowout,Gra,Rin; then T0.
REQ-020 mflo 11000: T3 LOout,Gra,Rin; mfhi 11001: T3 HIout,Gra,Rin; in 10110: T3 INout,Gra,Rin; out 10111: T3 Gra,Rout,OUT_Portin; each then T0.
REQ-021 nop 11010: T2 goes directly to T0 (3 cycles).
REQ-022 halt 11011: T2 goes to HALT; HALT holds all outputs 0 and run=0 until reset.
REQ-023 All other opcodes (ld, ldi, st, branch, jal, jr, 11100-11111): illegal=1 for one cycle in T3, no other outputs, then T0.
REQ-024 Exactly one bus_src bit, or Rout alone, drives the bus in any cycle; never two drivers.

Reset
REQ-025 While reset=1 at a clock edge: next state RST, regardless of current state, including mid-instruction and HALT.
REQ-026 In RST: con_reset=1, run=1, all other outputs 0; the first edge with reset=0 moves RST to T0.

Structure
REQ-027 Package cpu_ctrl_pkg holds opcode constants, the state enumeration, and the bit indices for bus_src, reg_ctl, ld_en, alu_op and mem_ctl.
REQ-028 One combinational sub-module, op_class_decode, maps an opcode to its instruction class and alu_op one-hot; the FSM lives in control_unit.

Verification
REQ-029 ir=0x1A920000 (add R5,R2,R4) -> T3 Grb,Rout,Yin; T4 Grc,Rout,ADD,Zin; T5 Zlowout,Gra,Rin; T0 at cycle 6.
REQ-030 ir=0x81880000 (mul R3,R1) -> T4 MUL,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin; next fetch T0 at cycle 7.
REQ-031 ir=0xC9800000 (mfhi R3) -> T3 HIout,Gra,Rin only; T0 next cycle.
REQ-032 ir=0x00000000 (ld) -> illegal pulse in T3 for exactly 1 cycle, no load enables; then T0.
REQ-033 ir=0xD8000000 (halt) -> HALT; run=0, all outputs 0 for 10 cycles; reset for 1 cycle -> RST (con_reset=1), then T0.
REQ-034 reset asserted in T4 of a mul -> RST on the next edge, Zin/HIin/LOin never asserted afterwards; fetch restarts at T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hard-wired CPU control unit: opcodes, FSM states,
// instruction classes and the bit positions of every control output vector.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  typedef enum logic [3:0] {
    CLS_ILLEGAL, CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_UNARY,
    CLS_MFLO, CLS_MFHI, CLS_IN, CLS_OUT, CLS_NOP, CLS_HALT
  } op_class_e;

  // bus_src bit positions
  localparam int B_HIOUT = 10, B_LOOUT = 9, B_ZHIGHOUT = 8, B_ZLOWOUT = 7;
  localparam int B_PCOUT = 6, B_IROUT = 5, B_MDROUT = 4, B_INOUT = 3;
  localparam int B_COUT = 2, B_YOUT = 1, B_MAROUT = 0;
  // reg_ctl bit positions
  localparam int R_GRA = 5, R_GRB = 4, R_GRC = 3, R_RIN = 2, R_ROUT = 1, R_BAOUT = 0;
  // ld_en bit positions
  localparam int L_HIIN = 9, L_LOIN = 8, L_PCIN = 7, L_IRIN = 6, L_ZIN = 5;
  localparam int L_YIN = 4, L_MARIN = 3, L_MDRIN = 2, L_CONIN = 1, L_OUTPIN = 0;
  // alu_op bit positions
  localparam int A_AND = 12, A_OR = 11, A_ADD = 10, A_SUB = 9, A_MUL = 8, A_DIV = 7;
  localparam int A_SHR = 6, A_SHRA = 5, A_SHL = 4, A_ROR = 3, A_ROL = 2, A_NEG = 1, A_NOT = 0;
  // mem_ctl bit positions
  localparam int M_READ = 3, M_INCPC = 2, M_READMEM = 1, M_WRITEMEM = 0;

endpackage

// File: rtl/op_class_decode.sv
// Purely combinational opcode decoder: instruction class plus the one-hot ALU
// operation that the class's execute step presents to the ALU.
module op_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]  opcode_i,
  output op_class_e   cls_o,
  output logic [12:0] alu_op_o
);

  always_comb begin
    cls_o    = CLS_ILLEGAL;
    alu_op_o = 13'b0;
    case (opcode_i)
      OP_ADD:  begin cls_o = CLS_RTYPE;  alu_op_o[A_ADD]  = 1'b1; end
      OP_SUB:  begin cls_o = CLS_RTYPE;  alu_op_o[A_SUB]  = 1'b1; end
      OP_AND:  begin cls_o = CLS_RTYPE;  alu_op_o[A_AND]  = 1'b1; end
      OP_OR:   begin cls_o = CLS_RTYPE;  alu_op_o[A_OR]   = 1'b1; end
      OP_ROR:  begin cls_o = CLS_RTYPE;  alu_op_o[A_ROR]  = 1'b1; end
      OP_ROL:  begin cls_o = CLS_RTYPE;  alu_op_o[A_ROL]  = 1'b1; end
      OP_SHR:  begin cls_o = CLS_RTYPE;  alu_op_o[A_SHR]  = 1'b1; end
      OP_SHRA: begin cls_o = CLS_RTYPE;  alu_op_o[A_SHRA] = 1'b1; end
      OP_SHL:  begin cls_o = CLS_RTYPE;  alu_op_o[A_SHL]  = 1'b1; end
      OP_ADDI: begin cls_o = CLS_IMM;    alu_op_o[A_ADD]  = 1'b1; end
      OP_ANDI: begin cls_o = CLS_IMM;    alu_op_o[A_AND]  = 1'b1; end
      OP_ORI:  begin cls_o = CLS_IMM;    alu_op_o[A_OR]   = 1'b1; end
      OP_DIV:  begin cls_o = CLS_MULDIV; alu_op_o[A_DIV]  = 1'b1; end
      OP_MUL:  begin cls_o = CLS_MULDIV; alu_op_o[A_MUL]  = 1'b1; end
      OP_NEG:  begin cls_o = CLS_UNARY;  alu_op_o[A_NEG]  = 1'b1; end
      OP_NOT:  begin cls_o = CLS_UNARY;  alu_op_o[A_NOT]  = 1'b1; end
      OP_MFLO: cls_o = CLS_MFLO;
      OP_MFHI: cls_o = CLS_MFHI;
      OP_IN:   cls_o = CLS_IN;
      OP_OUT:  cls_o = CLS_OUT;
      OP_NOP:  cls_o = CLS_NOP;
      OP_HALT: cls_o = CLS_HALT;
      default: cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hard-wired T-step control unit: fetch T0..T2, class-driven execute T3..T6,
// HALT sink left only by reset. Outputs are Moore-decoded from state and opcode.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  output logic [10:0] bus_src,
  output logic [5:0]  reg_ctl,
  output logic [9:0]  ld_en,
  output logic [12:0] alu_op,
  output logic [3:0]  mem_ctl,
  output logic        con_reset,
  output logic        run,
  output logic        illegal
);

  logic [3:0]  state_q, state_d;
  op_class_e   cls_s;
  logic [12:0] alu_s;
  logic        unused_ir_s;

  // Register fields are consumed by the datapath's select logic, not here.
  assign unused_ir_s = ^ir[26:0];

  op_class_decode u_dec (
    .opcode_i (ir[31:27]),
    .cls_o    (cls_s),
    .alu_op_o (alu_s)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (cls_s == CLS_NOP)       state_d = S_T0;
        else if (cls_s == CLS_HALT) state_d = S_HALT;
        else                        state_d = S_T3;
      end
      S_T3: begin
        if (cls_s == CLS_RTYPE || cls_s == CLS_IMM || cls_s == CLS_MULDIV || cls_s == CLS_UNARY)
          state_d = S_T4;
        else
          state_d = S_T0;
      end
      S_T4:   state_d = (cls_s == CLS_UNARY) ? S_T0 : S_T5;
      S_T5:   state_d = (cls_s == CLS_MULDIV) ? S_T6 : S_T0;
      S_T6:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    bus_src   = 11'b0;
    reg_ctl   = 6'b0;
    ld_en     = 10'b0;
    alu_op    = 13'b0;
    mem_ctl   = 4'b0;
    con_reset = 1'b0;
    run       = 1'b1;
    illegal   = 1'b0;
    case (state_q)
      S_RST: con_reset = 1'b1;
      S_T0: begin mem_ctl[M_INCPC] = 1'b1; ld_en[L_MARIN] = 1'b1; ld_en[L_PCIN] = 1'b1; end
      S_T1: begin ld_en[L_MDRIN] = 1'b1; mem_ctl[M_READ] = 1'b1; mem_ctl[M_READMEM] = 1'b1; end
      S_T2: begin bus_src[B_MDROUT] = 1'b1; ld_en[L_IRIN] = 1'b1; mem_ctl[M_READ] = 1'b1; end
      S_T3: begin
        case (cls_s)
          CLS_RTYPE, CLS_IMM: begin reg_ctl[R_GRB] = 1'b1; reg_ctl[R_ROUT] = 1'b1; ld_en[L_YIN] = 1'b1; end
          CLS_MULDIV: begin reg_ctl[R_GRA] = 1'b1; reg_ctl[R_ROUT] = 1'b1; ld_en[L_YIN] = 1'b1; end
          CLS_UNARY: begin
            reg_ctl[R_GRB] = 1'b1; reg_ctl[R_ROUT] = 1'b1; alu_op = alu_s; ld_en[L_ZIN] = 1'b1;
          end
          CLS_MFLO: begin bus_src[B_LOOUT] = 1'b1; reg_ctl[R_GRA] = 1'b1; reg_ctl[R_RIN] = 1'b1; end
          CLS_MFHI: begin bus_src[B_HIOUT] = 1'b1; reg_ctl[R_GRA] = 1'b1; reg_ctl[R_RIN] = 1'b1; end
          CLS_IN:   begin bus_src[B_INOUT] = 1'b1; reg_ctl[R_GRA] = 1'b1; reg_ctl[R_RIN] = 1'b1; end
          CLS_OUT:  begin reg_ctl[R_GRA] = 1'b1; reg_ctl[R_ROUT] = 1'b1; ld_en[L_OUTPIN] = 1'b1; end
          CLS_ILLEGAL: illegal = 1'b1;
          default: illegal = 1'b0;
        endcase
      end
      S_T4: begin
        case (cls_s)
          CLS_RTYPE: begin
            reg_ctl[R_GRC] = 1'b1; reg_ctl[R_ROUT] = 1'b1; alu_op = alu_s; ld_en[L_ZIN] = 1'b1;
          end
          CLS_IMM: begin bus_src[B_COUT] = 1'b1; alu_op = alu_s; ld_en[L_ZIN] = 1'b1; end
          CLS_MULDIV: begin
            reg_ctl[R_GRB] = 1'b1; reg_ctl[R_ROUT] = 1'b1; alu_op = alu_s; ld_en[L_ZIN] = 1'b1;
          end
          CLS_UNARY: begin bus_src[B_ZLOWOUT] = 1'b1; reg_ctl[R_GRA] = 1'b1; reg_ctl[R_RIN] = 1'b1; end
          default: alu_op = 13'b0;
        endcase
      end
      S_T5: begin
        case (cls_s)
          CLS_RTYPE, CLS_IMM: begin
            bus_src[B_ZLOWOUT] = 1'b1; reg_ctl[R_GRA] = 1'b1; reg_ctl[R_RIN] = 1'b1;
          end
          CLS_MULDIV: begin bus_src[B_ZLOWOUT] = 1'b1; ld_en[L_LOIN] = 1'b1; end
          default: alu_op = 13'b0;
        endcase
      end
      S_T6: begin
        if (cls_s == CLS_MULDIV) begin
          bus_src[B_ZHIGHOUT] = 1'b1; ld_en[L_HIIN] = 1'b1;
        end else begin
          bus_src = 11'b0;
        end
      end
      S_HALT: run = 1'b0;
      default: run = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: every step of each instruction class
// is compared against a hand-built expected control word.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir = 32'h0;
  logic [10:0] bus_src;
  logic [5:0]  reg_ctl;
  logic [9:0]  ld_en;
  logic [12:0] alu_op;
  logic [3:0]  mem_ctl;
  logic        con_reset, run, illegal;

  int checks = 0;
  int passed = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .ir(ir), .bus_src(bus_src), .reg_ctl(reg_ctl),
    .ld_en(ld_en), .alu_op(alu_op), .mem_ctl(mem_ctl), .con_reset(con_reset),
    .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Flat 47-bit control word: {bus_src, reg_ctl, ld_en, alu_op, mem_ctl, con_reset, run, illegal}
  wire [46:0] obs = {bus_src, reg_ctl, ld_en, alu_op, mem_ctl, con_reset, run, illegal};

  localparam logic [46:0] ONE = 47'd1;
  localparam logic [46:0] HIOUT = ONE << 46, LOOUT = ONE << 45, ZHI = ONE << 44, ZLO = ONE << 43;
  localparam logic [46:0] MDROUT = ONE << 40, INOUT = ONE << 39, COUT = ONE << 38;
  localparam logic [46:0] GRA = ONE << 35, GRB = ONE << 34, GRC = ONE << 33, RIN = ONE << 32, ROUT = ONE << 31;
  localparam logic [46:0] HIIN = ONE << 29, LOIN = ONE << 28, PCIN = ONE << 27, IRIN = ONE << 26;
  localparam logic [46:0] ZIN = ONE << 25, YIN = ONE << 24, MARIN = ONE << 23, MDRIN = ONE << 22;
  localparam logic [46:0] OUTPIN = ONE << 20;
  localparam logic [46:0] A_AND = ONE << 19, A_ADD = ONE << 17, A_MUL = ONE << 15, A_NOT = ONE << 7;
  localparam logic [46:0] READ = ONE << 6, INCPC = ONE << 5, RDMEM = ONE << 4;
  localparam logic [46:0] CONRST = ONE << 2, RUN = ONE << 1, ILL = ONE << 0;

  localparam logic [46:0] F0 = INCPC | MARIN | PCIN | RUN;
  localparam logic [46:0] F1 = MDRIN | READ | RDMEM | RUN;
  localparam logic [46:0] F2 = MDROUT | IRIN | READ | RUN;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset then release so the next sample is T0.
  task automatic go_t0(input logic [31:0] instr);
    ir = instr;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (obs !== (CONRST | RUN)) $display("FAIL reset_rst got %h expected %h", obs, CONRST | RUN);
    else passed++;
    reset = 1'b0;
    step();
    checks++;
    if (obs !== F0) $display("FAIL reset_to_t0 got %h expected %h", obs, F0);
    else passed++;
  endtask

  task automatic test_add();
    logic [46:0] e[7] = '{F0, F1, F2, GRB | ROUT | YIN | RUN, GRC | ROUT | A_ADD | ZIN | RUN,
                          ZLO | GRA | RIN | RUN, F0};
    go_t0(32'h1A920000);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      checks++;
      if (obs !== e[i]) $display("FAIL add step %0d got %h expected %h", i, obs, e[i]);
      else passed++;
    end
  endtask

  task automatic test_mul();
    logic [46:0] e[8] = '{F0, F1, F2, GRA | ROUT | YIN | RUN, GRB | ROUT | A_MUL | ZIN | RUN,
                          ZLO | LOIN | RUN, ZHI | HIIN | RUN, F0};
    go_t0(32'h81880000);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      checks++;
      if (obs !== e[i]) $display("FAIL mul step %0d got %h expected %h", i, obs, e[i]);
      else passed++;
    end
  endtask

  task automatic test_imm();
    logic [46:0] e[7] = '{F0, F1, F2, GRB | ROUT | YIN | RUN, COUT | A_AND | ZIN | RUN,
                          ZLO | GRA | RIN | RUN, F0};
    go_t0(32'h68000000);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      checks++;
      if (obs !== e[i]) $display("FAIL andi step %0d got %h expected %h", i, obs, e[i]);
      else passed++;
    end
  endtask

  task automatic test_unary();
    logic [46:0] e[6] = '{F0, F1, F2, GRB | ROUT | A_NOT | ZIN | RUN, ZLO | GRA | RIN | RUN, F0};
    go_t0(32'h90000000);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++;
      if (obs !== e[i]) $display("FAIL not step %0d got %h expected %h", i, obs, e[i]);
      else passed++;
    end
  endtask

  task automatic test_single_step();
    logic [31:0] ops[4] = '{32'hC9800000, 32'hC0000000, 32'hB0000000, 32'hB8000000};
    logic [46:0] t3[4]  = '{HIOUT | GRA | RIN | RUN, LOOUT | GRA | RIN | RUN,
                            INOUT | GRA | RIN | RUN, GRA | ROUT | OUTPIN | RUN};
    for (int k = 0; k < 4; k++) begin
      go_t0(ops[k]);
      step(); step(); step();
      checks++;
      if (obs !== t3[k]) $display("FAIL single_t3 op %h got %h expected %h", ops[k], obs, t3[k]);
      else passed++;
      step();
      checks++;
      if (obs !== F0) $display("FAIL single_next op %h got %h expected %h", ops[k], obs, F0);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ops[2] = '{32'h00000000, 32'hE0000000};
    logic [46:0] e[5] = '{F0, F1, F2, ILL | RUN, F0};
    for (int k = 0; k < 2; k++) begin
      go_t0(ops[k]);
      for (int i = 0; i < 5; i++) begin
        if (i > 0) step();
        checks++;
        if (obs !== e[i]) $display("FAIL illegal op %h step %0d got %h expected %h", ops[k], i, obs, e[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_nop();
    logic [46:0] e[4] = '{F0, F1, F2, F0};
    go_t0(32'hD0000000);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++;
      if (obs !== e[i]) $display("FAIL nop step %0d got %h expected %h", i, obs, e[i]);
      else passed++;
    end
  endtask

  task automatic test_halt();
    go_t0(32'hD8000000);
    step(); step();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs !== 47'd0) $display("FAIL halt cycle %0d got %h expected %h", i, obs, 47'd0);
      else passed++;
    end
    reset = 1'b1;
    step();
    checks++;
    if (obs !== (CONRST | RUN)) $display("FAIL halt_reset got %h expected %h", obs, CONRST | RUN);
    else passed++;
    reset = 1'b0;
    step();
    checks++;
    if (obs !== F0) $display("FAIL halt_restart got %h expected %h", obs, F0);
    else passed++;
  endtask

  task automatic test_reset_mid_mul();
    logic [46:0] e[4] = '{F0, F1, F2, GRA | ROUT | YIN | RUN};
    go_t0(32'h81880000);
    step(); step(); step(); step();
    checks++;
    if (obs !== (GRB | ROUT | A_MUL | ZIN | RUN)) $display("FAIL midmul_t4 got %h", obs);
    else passed++;
    reset = 1'b1;
    step();
    checks++;
    if (obs !== (CONRST | RUN)) $display("FAIL midmul_rst got %h expected %h", obs, CONRST | RUN);
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== e[i]) $display("FAIL midmul_restart step %0d got %h expected %h", i, obs, e[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_imm();
    test_unary();
    test_single_step();
    test_illegal();
    test_nop();
    test_halt();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
